// File: rtl/frame_pkg.sv
// frame_pkg: shared sizes and state type for the
// sample bank frame loader.
package frame_pkg;

  localparam int SLOTS   = 64;
  localparam int DATA_W  = 11;
  localparam int IDX_W   = $clog2(SLOTS);
  localparam int TIMEOUT = 255;
  localparam int TMR_W   = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

endpackage

// File: rtl/frame_loader_idle_timer.sv
// idle_timer: counts idle cycles inside a frame and
// flags the cycle on which the LIMIT-th one elapses.
module idle_timer
  import frame_pkg::*;
#(
  parameter int LIMIT = TIMEOUT,
  parameter int W     = TMR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] cnt;

  // cnt holds the idle cycles completed before this one
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/frame_loader.sv
// frame_loader: aligns a sample stream on start-of-frame
// and sequences writes into the 64-slot sample bank.
module frame_loader
  import frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           state;
  logic [IDX_W-1:0] next_idx;
  logic             hs;
  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_expired;

  assign in_ready  = (state != COMMIT);
  assign busy      = (state != IDLE);
  assign hs        = in_valid && in_ready;
  assign tmr_en    = (state == LOAD) && !hs;
  assign tmr_clear = (state != LOAD) || hs;

  idle_timer #(
    .LIMIT (TIMEOUT),
    .W     (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // frame sequencer with registered bank-write and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      next_idx   <= '0;
      wr_en      <= 1'b0;
      wr_idx     <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs && in_sof) begin
            wr_en    <= 1'b1;
            wr_idx   <= '0;
            wr_data  <= in_data;
            next_idx <= IDX_ONE;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (hs) begin
            wr_en   <= 1'b1;
            wr_data <= in_data;
            if (in_sof) begin
              frame_err <= 1'b1;
              wr_idx    <= '0;
              next_idx  <= IDX_ONE;
            end else begin
              wr_idx <= next_idx;
              if (next_idx == LAST_IDX) begin
                frame_done <= 1'b1;
                state      <= COMMIT;
              end else begin
                next_idx <= next_idx + 1'b1;
              end
            end
          end else if (tmr_expired) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        COMMIT: begin
          frame_cnt <= frame_cnt + 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
